// File: rtl/npc_sel_unit_if.sv
// Redirect, stall and instruction-fetch handshake bundle for npc_sel_unit.
// master = the PC unit; slave = the surrounding pipeline / instruction memory.
interface npc_sel_unit_if #(
  parameter int unsigned WIDTH = 32
) ();
  logic             jump_valid;
  logic [1:0]       jump_ctrl;
  logic [WIDTH-1:0] br_target;
  logic [WIDTH-1:0] j_target;
  logic [WIDTH-1:0] reg_target;
  logic             stall;
  logic             if_ack;
  logic             if_req;
  logic [WIDTH-1:0] if_addr;
  logic [WIDTH-1:0] pc;
  logic [WIDTH-1:0] pc4;
  logic             pend_valid;
  logic             align_err;

  modport master (
    input  jump_valid, jump_ctrl, br_target, j_target, reg_target, stall, if_ack,
    output if_req, if_addr, pc, pc4, pend_valid, align_err
  );

  modport slave (
    output jump_valid, jump_ctrl, br_target, j_target, reg_target, stall, if_ack,
    input  if_req, if_addr, pc, pc4, pend_valid, align_err
  );
endinterface

// File: rtl/npc_sel_unit.sv
// IF-stage program counter with next-PC select, redirect buffering and fetch handshake.
// Optional misaligned-target checking is enabled by defining PC_ALIGN_CHECK_EN.
module npc_sel_unit #(
  parameter int unsigned WIDTH    = 32,
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input logic            clk,
  input logic            rst_n,
  npc_sel_unit_if.master bus
);

  localparam logic [WIDTH-1:0] RST_PC  = WIDTH'(RESET_PC);
  localparam logic [WIDTH-1:0] PC_STEP = WIDTH'(4);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t           state, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] pc4_q;
  logic [WIDTH-1:0] pend_target_q, pend_target_d;
  logic             pend_valid_q, pend_valid_d;
  logic             if_req_q, if_req_d;
  logic             redirect;
  logic             advance;
  logic [WIDTH-1:0] live_target;
  logic [WIDTH-1:0] sel_target;
  logic             sel_is_jump;
`ifdef PC_ALIGN_CHECK_EN
  logic             align_err_q, align_err_d;
`endif

  // State register and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      pc_q          <= RST_PC;
      pc4_q         <= RST_PC + PC_STEP;
      pend_target_q <= '0;
      pend_valid_q  <= 1'b0;
      if_req_q      <= 1'b0;
`ifdef PC_ALIGN_CHECK_EN
      align_err_q   <= 1'b0;
`endif
    end else begin
      state         <= state_d;
      pc_q          <= pc_d;
      pc4_q         <= pc_d + PC_STEP;
      pend_target_q <= pend_target_d;
      pend_valid_q  <= pend_valid_d;
      if_req_q      <= if_req_d;
`ifdef PC_ALIGN_CHECK_EN
      align_err_q   <= align_err_d;
`endif
    end
  end

  // Next-state, next-PC selection and redirect buffering
  always_comb begin
    state_d       = state;
    pc_d          = pc_q;
    pend_target_d = pend_target_q;
    pend_valid_d  = pend_valid_q;
    if_req_d      = 1'b0;
    advance       = 1'b0;
    sel_target    = pc4_q;
    sel_is_jump   = 1'b0;
    live_target   = pc4_q;
    redirect      = bus.jump_valid && (bus.jump_ctrl != 2'b00);
`ifdef PC_ALIGN_CHECK_EN
    align_err_d   = align_err_q;
`endif

    case (bus.jump_ctrl)
      2'b01:   live_target = bus.br_target;
      2'b10:   live_target = bus.j_target;
      2'b11:   live_target = bus.reg_target;
      default: live_target = pc4_q;
    endcase

    case (state)
      IDLE:  state_d = FETCH;
      FETCH: begin
        if (bus.if_ack) begin
          if (bus.stall) state_d = HOLD;
          else           advance = 1'b1;
        end
      end
      HOLD: begin
        if (!bus.stall) begin
          advance = 1'b1;
          state_d = FETCH;
        end
      end
      default: state_d = IDLE;
    endcase

    if_req_d = (state_d == FETCH);

    // Live redirect beats a buffered one, which beats sequential fetch
    if (redirect) begin
      sel_target  = live_target;
      sel_is_jump = 1'b1;
    end else if (pend_valid_q) begin
      sel_target  = pend_target_q;
      sel_is_jump = 1'b1;
    end

    if (advance) begin
      pc_d         = sel_target;
      pend_valid_d = 1'b0;
`ifdef PC_ALIGN_CHECK_EN
      if (sel_is_jump && (sel_target[1:0] != 2'b00)) begin
        pc_d        = {sel_target[WIDTH-1:2], 2'b00};
        align_err_d = 1'b1;
      end
`endif
    end else if (redirect) begin
      pend_target_d = live_target;
      pend_valid_d  = 1'b1;
    end
  end

  assign bus.if_req     = if_req_q;
  assign bus.if_addr    = pc_q;
  assign bus.pc         = pc_q;
  assign bus.pc4        = pc4_q;
  assign bus.pend_valid = pend_valid_q;
`ifdef PC_ALIGN_CHECK_EN
  assign bus.align_err  = align_err_q;
`else
  assign bus.align_err  = 1'b0;
  logic unused_sel;
  assign unused_sel     = sel_is_jump;
`endif

endmodule

// File: tb/tb_npc_sel_unit.sv
// Directed bench for npc_sel_unit: scoreboard of expected post-edge state, plus
// an 8-bit instance running free to exercise PC wrap-around.
module tb_npc_sel_unit;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  npc_sel_unit_if #(.WIDTH(32)) bus ();
  npc_sel_unit_if #(.WIDTH(8))  bus8 ();

  npc_sel_unit #(.WIDTH(32), .RESET_PC(32'h0000_3000)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  npc_sel_unit #(.WIDTH(8), .RESET_PC(32'h0000_00FC)) dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus8.master)
  );

  assign bus8.jump_valid = 1'b0;
  assign bus8.jump_ctrl  = 2'b00;
  assign bus8.br_target  = 8'h00;
  assign bus8.j_target   = 8'h00;
  assign bus8.reg_target = 8'h00;
  assign bus8.stall      = 1'b0;
  assign bus8.if_ack     = 1'b1;

  typedef struct {
    string       tag;
    logic [31:0] pc;
    logic        req;
    logic        pend;
    logic        aerr;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

`ifdef PC_ALIGN_CHECK_EN
  localparam logic [31:0] MIS_PC   = 32'h0000_3004;
  localparam logic        MIS_AERR = 1'b1;
`else
  localparam logic [31:0] MIS_PC   = 32'h0000_3006;
  localparam logic        MIS_AERR = 1'b0;
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push(input string tag, input logic [31:0] pc, input logic req,
                      input logic pend, input logic aerr);
    exp_t e;
    e.tag  = tag;
    e.pc   = pc;
    e.req  = req;
    e.pend = pend;
    e.aerr = aerr;
    sb.push_back(e);
  endtask

  task automatic check_out();
    exp_t e;
    if (sb.size() == 0) begin
      tests++;
      fails++;
      $error("FAIL scoreboard_empty observed=0 entries expected=1");
    end else begin
      e = sb.pop_front();
      chk({e.tag, ".pc"},   bus.pc,              e.pc);
      chk({e.tag, ".addr"}, bus.if_addr,         e.pc);
      chk({e.tag, ".pc4"},  bus.pc4,             e.pc + 32'd4);
      chk({e.tag, ".req"},  32'(bus.if_req),     32'(e.req));
      chk({e.tag, ".pend"}, 32'(bus.pend_valid), 32'(e.pend));
      chk({e.tag, ".aerr"}, 32'(bus.align_err),  32'(e.aerr));
    end
  endtask

  task automatic drive(input logic jv, input logic [1:0] ctrl, input logic [31:0] br,
                       input logic [31:0] jt, input logic [31:0] rt,
                       input logic st, input logic ack);
    bus.jump_valid = jv;
    bus.jump_ctrl  = ctrl;
    bus.br_target  = br;
    bus.j_target   = jt;
    bus.reg_target = rt;
    bus.stall      = st;
    bus.if_ack     = ack;
  endtask

  // Expectation is queued with the stimulus, compared 1 time unit after the edge
  task automatic step(input string tag, input logic [31:0] pc, input logic req,
                      input logic pend, input logic aerr);
    push(tag, pc, req, pend, aerr);
    @(posedge clk);
    #1;
    check_out();
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1);
    #12;
    push("reset", 32'h3000, 1'b0, 1'b0, 1'b0);
    check_out();
    chk("w8_reset_pc", 32'(bus8.pc), 32'h0000_00FC);
    rst_n = 1'b1;

    step("fetch0", 32'h3000, 1'b1, 1'b0, 1'b0);
    chk("w8_pc_fc",   32'(bus8.pc),  32'h0000_00FC);
    chk("w8_pc4_fc",  32'(bus8.pc4), 32'h0000_0000);
    step("fetch1", 32'h3004, 1'b1, 1'b0, 1'b0);
    chk("w8_wrap",    32'(bus8.pc),  32'h0000_0000);
    chk("w8_pc4_00",  32'(bus8.pc4), 32'h0000_0004);
    step("fetch2", 32'h3008, 1'b1, 1'b0, 1'b0);
    step("fetch3", 32'h300C, 1'b1, 1'b0, 1'b0);
    step("fetch4", 32'h3010, 1'b1, 1'b0, 1'b0);

    drive(1'b1, 2'b01, 32'h3100, 32'h0, 32'h0, 1'b0, 1'b1);
    step("branch", 32'h3100, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 2'b10, 32'h0, 32'h3020, 32'h0, 1'b0, 1'b1);
    step("jump", 32'h3020, 1'b1, 1'b0, 1'b0);

    drive(1'b1, 2'b10, 32'h0, 32'h4000, 32'h0, 1'b0, 1'b0);
    step("buf_jump", 32'h3020, 1'b1, 1'b1, 1'b0);
    drive(1'b1, 2'b11, 32'h0, 32'h0, 32'h5000, 1'b0, 1'b0);
    step("buf_reg", 32'h3020, 1'b1, 1'b1, 1'b0);
    drive(1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1);
    step("pend_apply", 32'h5000, 1'b1, 1'b0, 1'b0);

    drive(1'b0, 2'b11, 32'h0, 32'h0, 32'h9990, 1'b0, 1'b1);
    step("jv_low", 32'h5004, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 2'b00, 32'h1234, 32'h1234, 32'h1234, 1'b0, 1'b1);
    step("ctrl_none", 32'h5008, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 2'b11, 32'h0, 32'h0, 32'h3040, 1'b0, 1'b1);
    step("reg_jump", 32'h3040, 1'b1, 1'b0, 1'b0);

    drive(1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 1'b1, 1'b1);
    step("hold_enter", 32'h3040, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);
    step("hold_1", 32'h3040, 1'b0, 1'b0, 1'b0);
    step("hold_2", 32'h3040, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    step("hold_exit", 32'h3044, 1'b1, 1'b0, 1'b0);

    drive(1'b1, 2'b01, 32'h7000, 32'h0, 32'h0, 1'b1, 1'b1);
    step("hold_buf", 32'h3044, 1'b0, 1'b1, 1'b0);
    drive(1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    step("hold_pend", 32'h7000, 1'b1, 1'b0, 1'b0);

    drive(1'b1, 2'b10, 32'h0, 32'h8000, 32'h0, 1'b0, 1'b0);
    step("buf_again", 32'h7000, 1'b1, 1'b1, 1'b0);
    drive(1'b1, 2'b11, 32'h0, 32'h0, 32'h9000, 1'b0, 1'b1);
    step("live_over_pend", 32'h9000, 1'b1, 1'b0, 1'b0);

    drive(1'b1, 2'b11, 32'h0, 32'h0, 32'h3006, 1'b0, 1'b1);
    step("misalign", MIS_PC, 1'b1, 1'b0, MIS_AERR);
    drive(1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1);
    step("aerr_sticky", MIS_PC + 32'd4, 1'b1, 1'b0, MIS_AERR);
    drive(1'b1, 2'b10, 32'h0, 32'hA000, 32'h0, 1'b0, 1'b0);
    step("pre_reset", MIS_PC + 32'd4, 1'b1, 1'b1, MIS_AERR);

    #2;
    rst_n = 1'b0;
    #1;
    push("reset_mid", 32'h3000, 1'b0, 1'b0, 1'b0);
    check_out();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive(1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1);
    step("restart0", 32'h3000, 1'b1, 1'b0, 1'b0);
    step("restart1", 32'h3004, 1'b1, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
